tdm_demux8: RTL and testbench
=============================

Name: tdm_demux8

Overview:
- 8-channel time-division demultiplexer. It is the receive end of the team's 8:1 slot-multiplexed links.
- Takes a serial per-slot stream plus a frame-sync marker and locks to the frame. It routes each slot's sample to its channel and presents all 8 channels in parallel once per frame.
- Includes flywheel sync tracking, misalignment detection and loss-of-lock recovery.

Parameters:
- DW, 1, width of one channel sample (din width); dout is 8*DW bits.
- MISS_LIMIT, 3, consecutive slot-0 beats without frame_sync before lock is dropped (range 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  beat strobe; din and frame_sync are sampled only when en=1
- frame_sync  input  1  marks the beat carrying slot 0
- din  input  DW  sample for the current slot
- dout  output  8*DW  last complete frame; channel k occupies dout[k*DW +: DW]
- frame_valid  output  1  one-cycle pulse: dout has just been updated
- slot  output  3  slot index the next beat will be assigned to
- locked  output  1  1 while in LOCKED state
- sync_err  output  1  one-cycle pulse: frame_sync arrived at a nonzero slot

Behaviour:
- Reset (async assert, sync release):
  - dout=0, frame_valid=0, slot=0, locked=0, sync_err=0.
  - Internal staging registers and miss counter are cleared; state is HUNT.
- All state changes occur only on clk edges with en=1, except that frame_valid and sync_err return to 0 on the next edge regardless of en.
- HUNT:
  - en=1 & frame_sync=1: store din as slot 0, set slot=1, go to LOCKED, clear miss counter.
  - Otherwise the beat is discarded and slot stays 0.
- LOCKED, beat at slot s:
  - s=1..7, frame_sync=0: store din as channel s; slot=s+1 (mod 8).
  - s=7 beat: on the same edge, dout loads staging channels 0..6 plus the current din as channel 7. frame_valid=1 for the following cycle. Latency is 1 clock from the slot-7 sample edge to valid dout.
  - s=1..7, frame_sync=1: sync_err=1 for one cycle. The partial frame is discarded (dout unchanged, no frame_valid). The beat is stored as slot 0, slot=1, miss counter is cleared, and the state stays LOCKED.
  - s=0, frame_sync=1: store as slot 0, clear miss counter, slot=1.
  - s=0, frame_sync=0 (flywheel): increment the miss counter.
    - If the new count is below MISS_LIMIT: store the beat as slot 0, slot=1.
    - If the count reaches MISS_LIMIT: discard the beat, go to HUNT, locked=0, slot=0, clear miss counter. dout keeps its last value.
- No frame_valid is ever produced for a frame that did not start on a slot-0 beat in LOCKED.
- en=0 holds all state; gaps of any length between beats are legal.
- Reset mid-frame: everything returns to the reset values immediately. The next frame requires a fresh frame_sync.
- dout is only ever written whole, never per-channel.

Test Plan:
- Reset, then 8 beats with en=1, frame_sync on beat 0, din=0,1,0,1,1,0,0,1 (DW=1) -> locked=1 after beat 0; dout=8'b1001_1010 one clock after beat 7 with frame_valid pulse; slot wraps to 0.
- Two back-to-back frames, second frame_sync present, din all 1 -> two frame_valid pulses 8 beats apart; second dout=8'hFF.
- Beats with frame_sync=0 from reset (10 beats) -> locked stays 0, slot=0, no frame_valid.
- Locked, frame_sync asserted at slot 3 -> sync_err pulse; no frame_valid; the following 7 beats complete a frame with channel 0 = data from the sync beat.
- Locked, frame_sync withheld at slot 0 for 3 consecutive frames (MISS_LIMIT=3) -> frames 1-2 still produce frame_valid; the third slot-0 beat drops lock (locked=0, slot=0); a new frame_sync relocks.
- Irregular en (1 beat every 3 clocks) plus async rst_n pulse at slot 5 -> outputs return to 0 immediately; the partial frame is never emitted.

Source files
------------

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive end of an 8:1 slot-multiplexed link.
// Locks to frame_sync, stages slots 0..6, and publishes the complete frame
// (slot 7 taken straight from din) on the slot-7 beat. A flywheel tolerates
// up to MISS_LIMIT-1 missing sync marks before lock is dropped.
module tdm_demux8 #(
   parameter int DW         = 1,
   parameter int MISS_LIMIT = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            frame_sync,
   input  logic [DW-1:0]   din,
   output logic [8*DW-1:0] dout,
   output logic            frame_valid,
   output logic [2:0]      slot,
   output logic            locked,
   output logic            sync_err
);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     stage_q [7];
   logic [3:0]        miss_q;
   logic [4:0]        miss_inc;
   logic              drop;
   logic [8*DW-1:0]   frame_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= HUNT;
      else        state_q <= state_d;
   end

   // Next-state: HUNT waits for a sync beat; LOCKED falls back to HUNT once
   // the flywheel has seen MISS_LIMIT consecutive slot-0 beats without sync.
   always_comb begin
      miss_inc = {1'b0, miss_q} + 5'd1;
      drop     = 1'b0;
      state_d  = state_q;
      if (en) begin
         if (state_q == HUNT) begin
            if (frame_sync) state_d = LOCKED;
         end else if (slot == 3'd0 && !frame_sync && miss_inc >= 5'(MISS_LIMIT)) begin
            drop    = 1'b1;
            state_d = HUNT;
         end
      end
   end

   // Output decode
   always_comb begin
      locked = (state_q == LOCKED);
   end

   // Frame assembly: staged slots 0..6 plus the live slot-7 sample
   always_comb begin
      frame_d = '0;
      for (int k = 0; k < 7; k++) frame_d[k*DW +: DW] = stage_q[k];
      frame_d[7*DW +: DW] = din;
   end

   // Slot routing, staging, frame publication and sync/miss bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 7; k++) stage_q[k] <= '0;
         dout        <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         slot        <= 3'd0;
         miss_q      <= 4'd0;
      end else begin
         // Pulses last exactly one cycle regardless of en
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         if (en) begin
            if (state_q == HUNT) begin
               if (frame_sync) begin
                  stage_q[0] <= din;
                  slot       <= 3'd1;
                  miss_q     <= 4'd0;
               end
            end else if (slot != 3'd0 && frame_sync) begin
               // Misaligned sync: abandon the partial frame and restart here
               sync_err   <= 1'b1;
               stage_q[0] <= din;
               slot       <= 3'd1;
               miss_q     <= 4'd0;
            end else if (slot == 3'd0) begin
               if (frame_sync) begin
                  stage_q[0] <= din;
                  slot       <= 3'd1;
                  miss_q     <= 4'd0;
               end else if (!drop) begin
                  stage_q[0] <= din;
                  slot       <= 3'd1;
                  miss_q     <= miss_inc[3:0];
               end else begin
                  slot   <= 3'd0;
                  miss_q <= 4'd0;
               end
            end else if (slot == 3'd7) begin
               dout        <= frame_d;
               frame_valid <= 1'b1;
               slot        <= 3'd0;
            end else begin
               stage_q[slot] <= din;
               slot          <= slot + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux8.sv
// Testbench for tdm_demux8 (DW=1, MISS_LIMIT=3).
module tb_tdm_demux8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       frame_sync;
   logic [0:0] din;
   logic [7:0] dout;
   logic       frame_valid;
   logic [2:0] slot;
   logic       locked;
   logic       sync_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] sb [$];

   typedef struct {
      logic       en;
      logic       fs;
      logic       din;
      logic [2:0] slot;
      logic       lk;
      logic       fv;
      logic       se;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs [$];

   tdm_demux8 #(.DW(1), .MISS_LIMIT(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .frame_sync  (frame_sync),
      .din         (din),
      .dout        (dout),
      .frame_valid (frame_valid),
      .slot        (slot),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void v(input logic e, input logic fs, input logic d,
                             input logic [2:0] s, input logic lk, input logic fv,
                             input logic se, input logic [7:0] dq);
      vec_t r;
      r.en = e; r.fs = fs; r.din = d; r.slot = s; r.lk = lk; r.fv = fv; r.se = se; r.dout = dq;
      vecs.push_back(r);
   endfunction

   // Scoreboard: every frame_valid pulse must match the next queued frame
   always @(negedge clk) begin
      if (rst_n === 1'b1 && frame_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got dout %0h with no frame queued", dout);
         end else begin
            chk("sb_frame", dout, sb.pop_front());
         end
      end
   end

   task automatic beat(input logic fs, input logic d, input int idle);
      en = 1'b1; frame_sync = fs; din = d;
      @(posedge clk); #1;
      en = 1'b0; frame_sync = 1'b0;
      for (int i = 0; i < idle; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] pat;
      en = 1'b0; frame_sync = 1'b0; din = 1'b0; rst_n = 1'b0;

      // ---- Vector table ----
      // No sync from reset: nothing locks, nothing is emitted
      for (int i = 0; i < 10; i++) v(1, 0, i[0], 3'd0, 0, 0, 0, 8'h00);
      // First frame: din 0,1,0,1,1,0,0,1 -> 8'h9A
      pat = 8'b1001_1010;
      v(1, 1, pat[0], 3'd1, 1, 0, 0, 8'h00);
      for (int k = 1; k < 7; k++) v(1, 0, pat[k], 3'(k + 1), 1, 0, 0, 8'h00);
      v(1, 0, pat[7], 3'd0, 1, 1, 0, 8'h9A);
      v(0, 0, 1'b0, 3'd0, 1, 0, 0, 8'h9A);
      // Two back-to-back frames of all ones
      for (int f = 0; f < 2; f++) begin
         v(1, 1, 1'b1, 3'd1, 1, 0, 0, (f == 0) ? 8'h9A : 8'hFF);
         for (int k = 1; k < 7; k++) v(1, 0, 1'b1, 3'(k + 1), 1, 0, 0, (f == 0) ? 8'h9A : 8'hFF);
         v(1, 0, 1'b1, 3'd0, 1, 1, 0, 8'hFF);
      end
      // Misaligned sync at slot 3; restarted frame -> 8'h4D
      v(1, 1, 1'b1, 3'd1, 1, 0, 0, 8'hFF);
      v(1, 0, 1'b0, 3'd2, 1, 0, 0, 8'hFF);
      v(1, 0, 1'b0, 3'd3, 1, 0, 0, 8'hFF);
      v(1, 1, 1'b1, 3'd1, 1, 0, 1, 8'hFF);
      pat = 8'h4D;
      for (int k = 1; k < 7; k++) v(1, 0, pat[k], 3'(k + 1), 1, 0, 0, 8'hFF);
      v(1, 0, pat[7], 3'd0, 1, 1, 0, 8'h4D);
      // Flywheel frame 1 (miss 1): ch0=0, rest 1 -> 8'hFE
      v(1, 0, 1'b0, 3'd1, 1, 0, 0, 8'h4D);
      for (int k = 1; k < 7; k++) v(1, 0, 1'b1, 3'(k + 1), 1, 0, 0, 8'h4D);
      v(1, 0, 1'b1, 3'd0, 1, 1, 0, 8'hFE);
      // Flywheel frame 2 (miss 2): ch0=1, rest 0 -> 8'h01
      v(1, 0, 1'b1, 3'd1, 1, 0, 0, 8'hFE);
      for (int k = 1; k < 7; k++) v(1, 0, 1'b0, 3'(k + 1), 1, 0, 0, 8'hFE);
      v(1, 0, 1'b0, 3'd0, 1, 1, 0, 8'h01);
      // Third missed sync drops lock; dout keeps its value
      v(1, 0, 1'b1, 3'd0, 0, 0, 0, 8'h01);
      v(1, 0, 1'b1, 3'd0, 0, 0, 0, 8'h01);
      // Relock with a fresh sync, all ones -> 8'hFF
      v(1, 1, 1'b1, 3'd1, 1, 0, 0, 8'h01);
      for (int k = 1; k < 7; k++) v(1, 0, 1'b1, 3'(k + 1), 1, 0, 0, 8'h01);
      v(1, 0, 1'b1, 3'd0, 1, 1, 0, 8'hFF);

      // ---- Reset state ----
      #12;
      chk("rst_dout", dout, 8'h00);
      chk("rst_fv", frame_valid, 1'b0);
      chk("rst_slot", slot, 3'd0);
      chk("rst_locked", locked, 1'b0);
      chk("rst_serr", sync_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ---- Apply table ----
      for (int i = 0; i < vecs.size(); i++) begin
         en = vecs[i].en; frame_sync = vecs[i].fs; din = vecs[i].din;
         if (vecs[i].fv) sb.push_back(vecs[i].dout);
         @(posedge clk); #1;
         chk($sformatf("v%0d_slot", i), slot, vecs[i].slot);
         chk($sformatf("v%0d_locked", i), locked, vecs[i].lk);
         chk($sformatf("v%0d_fv", i), frame_valid, vecs[i].fv);
         chk($sformatf("v%0d_serr", i), sync_err, vecs[i].se);
         chk($sformatf("v%0d_dout", i), dout, vecs[i].dout);
      end
      en = 1'b0; frame_sync = 1'b0;
      @(posedge clk); #1;
      chk("fv_clears_without_en", frame_valid, 1'b0);

      // ---- Irregular en with async reset at slot 5 ----
      beat(1'b1, 1'b0, 2);
      chk("irr_lock", locked, 1'b1);
      chk("irr_slot1", slot, 3'd1);
      for (int k = 1; k < 5; k++) beat(1'b0, 1'b1, 2);
      chk("irr_slot5_held", slot, 3'd5);
      chk("irr_dout_held", dout, 8'hFF);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_dout", dout, 8'h00);
      chk("async_rst_slot", slot, 3'd0);
      chk("async_rst_locked", locked, 1'b0);
      chk("async_rst_fv", frame_valid, 1'b0);
      chk("async_rst_serr", sync_err, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      // Remaining beats of the interrupted frame must not lock or emit anything
      for (int k = 0; k < 4; k++) beat(1'b0, 1'b1, 2);
      chk("post_rst_locked", locked, 1'b0);
      chk("post_rst_slot", slot, 3'd0);
      chk("post_rst_dout", dout, 8'h00);
      repeat (4) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
